// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory with sign/zero-extending loads, address fault
// detection, a READ_LATENCY-deep response pipeline and valid/ready handshakes.
module data_memory_bytelane #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Req_Valid_i,
    output logic                  Req_Ready_o,
    input  logic                  Mem_Write_i,
    input  logic [1:0]            Size_i,
    input  logic                  Unsigned_i,
    input  logic [DATA_WIDTH-1:0] Address_i,
    input  logic [DATA_WIDTH-1:0] Write_Data_i,
    output logic                  Rsp_Valid_o,
    input  logic                  Rsp_Ready_i,
    output logic [DATA_WIDTH-1:0] Read_Data_o,
    output logic                  Fault_o,
    output logic [DATA_WIDTH-1:0] Fault_Addr_o
);

    localparam int          IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [31:0] SPAN  = 32'(4 * MEMORY_DEPTH);
    localparam int          LAST  = READ_LATENCY - 1;

    logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];

    logic [READ_LATENCY-1:0] valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q  [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   data_d  [READ_LATENCY];
    logic [READ_LATENCY-1:0] fault_q, fault_d;
    logic [DATA_WIDTH-1:0]   fault_addr_q, fault_addr_d;

    logic                  stall;
    logic                  accept;
    logic [31:0]           offset;
    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  req_fault;
    logic                  mem_we;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata_lanes;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] load_ext;

    assign Rsp_Valid_o  = valid_q[LAST];
    assign Read_Data_o  = data_q[LAST];
    assign Fault_o      = fault_q[LAST];
    assign Fault_Addr_o = fault_addr_q;

    // Handshake, address decode and fault classification
    always_comb begin
        stall       = valid_q[LAST] & ~Rsp_Ready_i;
        Req_Ready_o = rst_n & ~stall;
        accept      = Req_Valid_i & Req_Ready_o;
        offset      = Address_i - BASE_ADDR;
        idx         = offset[IDX_W+1:2];
        in_range    = (offset < SPAN);
        req_fault   = ~in_range
                    | (Size_i == 2'b11)
                    | ((Size_i == 2'b01) & Address_i[0])
                    | ((Size_i == 2'b10) & (Address_i[1:0] != 2'b00));
        mem_we      = accept & Mem_Write_i & ~req_fault;
        rd_word     = in_range ? mem_q[idx] : '0;
    end

    // Lane enables, replicated store data and extended load data per access size
    always_comb begin
        be          = 4'b0000;
        wdata_lanes = Write_Data_i;
        load_ext    = '0;
        sel_byte    = rd_word[{Address_i[1:0], 3'b000} +: 8];
        sel_half    = Address_i[1] ? rd_word[31:16] : rd_word[15:0];
        case (Size_i)
            2'b00: begin
                be          = 4'b0001 << Address_i[1:0];
                wdata_lanes = {4{Write_Data_i[7:0]}};
                load_ext    = Unsigned_i ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            2'b01: begin
                be          = Address_i[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{Write_Data_i[15:0]}};
                load_ext    = Unsigned_i ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
            end
            2'b10: begin
                be       = 4'b1111;
                load_ext = rd_word;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

    // Response pipeline: every stage advances unless the head response is stalled
    always_comb begin
        valid_d      = valid_q;
        fault_d      = fault_q;
        data_d       = data_q;
        fault_addr_d = fault_addr_q;
        if (accept && req_fault) begin
            fault_addr_d = Address_i;
        end
        if (!stall) begin
            valid_d[0] = accept;
            fault_d[0] = accept & req_fault;
            data_d[0]  = (accept && !Mem_Write_i && !req_fault) ? load_ext : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                fault_d[i] = fault_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    // Pipeline and fault-address registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= '0;
            fault_q      <= '0;
            fault_addr_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // RAM array: per-lane writes on the accepting edge, contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Scoreboard bench for data_memory_bytelane: byte-addressed reference model,
// directed scenarios followed by randomized traffic with random backpressure.
module tb_data_memory_bytelane;

    localparam int          LAT   = 3;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic        clk;
    logic        rst_n;
    logic        Req_Valid_i;
    logic        Req_Ready_o;
    logic        Mem_Write_i;
    logic [1:0]  Size_i;
    logic        Unsigned_i;
    logic [31:0] Address_i;
    logic [31:0] Write_Data_i;
    logic        Rsp_Valid_o;
    logic        Rsp_Ready_i;
    logic [31:0] Read_Data_o;
    logic        Fault_o;
    logic [31:0] Fault_Addr_o;

    data_memory_bytelane #(
        .DATA_WIDTH  (32),
        .MEMORY_DEPTH(DEPTH),
        .BASE_ADDR   (BASE),
        .READ_LATENCY(LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Req_Valid_i (Req_Valid_i),
        .Req_Ready_o (Req_Ready_o),
        .Mem_Write_i (Mem_Write_i),
        .Size_i      (Size_i),
        .Unsigned_i  (Unsigned_i),
        .Address_i   (Address_i),
        .Write_Data_i(Write_Data_i),
        .Rsp_Valid_o (Rsp_Valid_o),
        .Rsp_Ready_i (Rsp_Ready_i),
        .Read_Data_o (Read_Data_o),
        .Fault_o     (Fault_o),
        .Fault_Addr_o(Fault_Addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          acc_cyc;
        int          acc_stall;
    } exp_t;

    exp_t        sb[$];
    exp_t        head;
    exp_t        e;
    logic [7:0]  mem_b [4*DEPTH];
    logic [31:0] fa_model;
    int          cyc;
    int          stall_cnt;
    int          n_checks;
    int          n_fail;
    bit          rsp_random;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: byte-addressed little-endian memory, extension by arithmetic
    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t        r;
        logic [31:0] off;
        int          n;
        longint      v;
        bit          flt;
        off = a - BASE;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        flt = (off >= 32'(4*DEPTH)) || (sz == 2'd3) || (sz == 2'd1 && a[0])
              || (sz == 2'd2 && a[1:0] != 2'b00);
        r.data  = '0;
        r.fault = flt;
        r.acc_cyc   = 0;
        r.acc_stall = 0;
        if (flt) begin
            fa_model = a;
        end else if (we) begin
            for (int k = 0; k < n; k++) mem_b[off + k] = wd[8*k +: 8];
        end else begin
            v = 0;
            for (int k = 0; k < n; k++) v += longint'(mem_b[off + k]) << (8*k);
            if (!uns && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
            r.data = v[31:0];
        end
        return r;
    endfunction

    // Monitor: compare head of scoreboard whenever a response is presented
    always @(negedge clk) begin
        cyc++;
        chk("fault_addr", Fault_Addr_o, fa_model);
        if (!rst_n) begin
            chk("req_ready_in_reset", {31'b0, Req_Ready_o}, 32'd0);
            sb.delete();
            fa_model = '0;
        end else begin
            chk("req_ready", {31'b0, Req_Ready_o}, {31'b0, !(Rsp_Valid_o && !Rsp_Ready_i)});
            if (Rsp_Valid_o) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got data %h fault %b with empty scoreboard", Read_Data_o, Fault_o);
                end else begin
                    head = sb[0];
                    chk("rsp_data", Read_Data_o, head.data);
                    chk("rsp_fault", {31'b0, Fault_o}, {31'b0, head.fault});
                    if (Rsp_Ready_i) begin
                        chk("latency", 32'(cyc - head.acc_cyc), 32'(LAT + stall_cnt - head.acc_stall));
                        void'(sb.pop_front());
                    end
                end
                if (!Rsp_Ready_i) stall_cnt++;
            end
            if (Req_Valid_i && Req_Ready_o) begin
                e = model(Mem_Write_i, Size_i, Unsigned_i, Address_i, Write_Data_i);
                e.acc_cyc   = cyc;
                e.acc_stall = stall_cnt;
                sb.push_back(e);
            end
        end
    end

    // Random backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rsp_random) Rsp_Ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one request and hold it until accepted (called at posedge+1)
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        bit acc;
        acc          = 1'b0;
        Req_Valid_i  = 1'b1;
        Mem_Write_i  = we;
        Size_i       = sz;
        Unsigned_i   = uns;
        Address_i    = a;
        Write_Data_i = wd;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = Req_Ready_o;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: request at %h never accepted", a);
        end
        Req_Valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int w;
        int pick;
        pick = $urandom_range(0, 9);
        if (pick == 0) return BASE + 32'(4*DEPTH) + 32'($urandom_range(0, 15));
        if (pick == 1) return BASE - 32'($urandom_range(1, 8));
        w = (pick < 8) ? $urandom_range(0, 15) : $urandom_range(DEPTH-2, DEPTH-1);
        return BASE + 32'(4*w) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        cyc = 0; stall_cnt = 0; n_checks = 0; n_fail = 0; fa_model = '0;
        rsp_random = 1'b0;
        rst_n = 1'b0; Req_Valid_i = 1'b0; Mem_Write_i = 1'b0; Size_i = 2'b00;
        Unsigned_i = 1'b0; Address_i = '0; Write_Data_i = '0; Rsp_Ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", {31'b0, Rsp_Valid_o}, 32'd0);
        chk("reset_read_data", Read_Data_o, 32'd0);
        rst_n = 1'b1;

        // Initialise the region used by random traffic
        for (int w = 0; w < 16; w++) issue(1'b1, 2'd2, 1'b0, BASE + 32'(4*w), $urandom);
        issue(1'b1, 2'd2, 1'b0, BASE + 32'(4*(DEPTH-2)), $urandom);
        issue(1'b1, 2'd2, 1'b0, BASE + 32'(4*(DEPTH-1)), $urandom);
        drain();

        // Word store then load
        issue(1'b1, 2'd2, 1'b0, BASE, 32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 1'b0, BASE, 32'h0);
        drain();

        // Byte store and signed/unsigned byte loads
        issue(1'b1, 2'd0, 1'b0, BASE + 32'd2, 32'h0000_0080);
        issue(1'b0, 2'd0, 1'b0, BASE + 32'd2, 32'h0);
        issue(1'b0, 2'd0, 1'b1, BASE + 32'd2, 32'h0);
        issue(1'b0, 2'd2, 1'b0, BASE, 32'h0);
        issue(1'b0, 2'd1, 1'b0, BASE + 32'd2, 32'h0);
        issue(1'b0, 2'd1, 1'b1, BASE + 32'd2, 32'h0);
        drain();

        // Faults: misaligned half, out-of-range word, illegal size, below base
        issue(1'b0, 2'd1, 1'b0, BASE + 32'd1, 32'h0);
        issue(1'b1, 2'd2, 1'b0, BASE + 32'(4*DEPTH), 32'h1234_5678);
        issue(1'b1, 2'd3, 1'b0, BASE + 32'd4, 32'hFFFF_FFFF);
        issue(1'b1, 2'd2, 1'b0, BASE - 32'd4, 32'h5555_5555);
        issue(1'b1, 2'd2, 1'b0, BASE + 32'd2, 32'hAAAA_AAAA);
        issue(1'b0, 2'd2, 1'b0, BASE, 32'h0);
        issue(1'b0, 2'd2, 1'b0, BASE + 32'd4, 32'h0);
        drain();

        // Back-to-back loads under backpressure
        Rsp_Ready_i = 1'b0;
        fork
            begin
                issue(1'b0, 2'd2, 1'b0, BASE, 32'h0);
                issue(1'b0, 2'd0, 1'b0, BASE + 32'd3, 32'h0);
                issue(1'b0, 2'd1, 1'b1, BASE + 32'd6, 32'h0);
                issue(1'b0, 2'd2, 1'b0, BASE + 32'd8, 32'h0);
            end
            begin
                repeat (LAT + 5) @(posedge clk);
                #1;
                Rsp_Ready_i = 1'b1;
            end
        join
        drain();

        // Randomized traffic with random backpressure
        rsp_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  rand_addr(), $urandom);
        end
        drain();
        rsp_random = 1'b0;
        Rsp_Ready_i = 1'b1;
        @(posedge clk);
        #1;

        // Reset with two loads in flight
        issue(1'b1, 2'd2, 1'b0, BASE + 32'd12, 32'hCAFE_F00D);
        issue(1'b0, 2'd2, 1'b0, BASE, 32'h0);
        issue(1'b0, 2'd2, 1'b0, BASE + 32'd12, 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_rsp_valid", {31'b0, Rsp_Valid_o}, 32'd0);
        chk("post_reset_fault", {31'b0, Fault_o}, 32'd0);
        repeat (LAT + 4) @(posedge clk);
        #1;
        issue(1'b0, 2'd2, 1'b0, BASE + 32'd12, 32'h0);
        issue(1'b0, 2'd0, 1'b1, BASE + 32'd2, 32'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/data_memory_bytelane.md
Name: data_memory_bytelane

Overview:
- Parametrised successor to the single-cycle data memory.
- Adds byte/halfword/word access with per-byte write lanes, sign/zero load extension, base-address decode with range and alignment fault reporting, a configurable read pipeline, and a valid/ready request/response handshake with backpressure.
- Sits between the load/store unit and the RAM array. Serves the pipelined core and remains usable by the single-cycle core with READ_LATENCY=1 and Rsp_Ready_i tied high.

Parameters:
DATA_WIDTH, 32, data and address width; fixed at 32 (4 byte lanes).
MEMORY_DEPTH, 1024, number of words in the array.
BASE_ADDR, 32'h1001_0000, byte address of word 0.
READ_LATENCY, 1, cycles from request acceptance to response; legal range 1..4.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
Req_Valid_i  in  1  request present.
Req_Ready_o  out  1  request can be accepted this cycle.
Mem_Write_i  in  1  1 = store, 0 = load.
Size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
Unsigned_i  in  1  zero-extend byte/half loads.
Address_i  in  32  byte address.
Write_Data_i  in  32  store data, right-aligned.
Rsp_Valid_o  out  1  response present.
Rsp_Ready_i  in  1  consumer takes response.
Read_Data_o  out  32  extended load data; 0 for stores and faults.
Fault_o  out  1  response belongs to a faulted request.
Fault_Addr_o  out  32  address of the most recent faulted request.

Behaviour:
- Accept = Req_Valid_i & Req_Ready_o. Req_Ready_o = rst_n & ~(Rsp_Valid_o & ~Rsp_Ready_i).
- offset = Address_i - BASE_ADDR (32-bit wrap). Word index = offset[31:2].
- Fault on accept when any of the following holds; a faulted store writes nothing:
  - offset >= 4*MEMORY_DEPTH (includes addresses below BASE_ADDR via wrap);
  - Size_i=11;
  - half with Address_i[0]=1;
  - word with Address_i[1:0]!=0.
- Store lanes:
  - byte: lane Address_i[1:0] gets Write_Data_i[7:0];
  - half: lanes {A[1],0} and {A[1],1} get Write_Data_i[15:0];
  - word: all four lanes.
  - Other lanes are untouched. The write commits on the accepting edge.
- Load: the array word is read and extended at accept time, then carried through the pipeline.
  - byte: lane A[1:0] is selected, sign-extended from bit 7 unless Unsigned_i.
  - half: lanes selected as for stores, sign-extended from bit 15 unless Unsigned_i.
  - word: Unsigned_i is ignored.
- Every accepted request, load or store, yields exactly one response, in order, exactly READ_LATENCY cycles later when there is no backpressure.
- Pipeline is READ_LATENCY stages of {valid, data, fault}. When Rsp_Valid_o & ~Rsp_Ready_i, all stages hold and no request is accepted.
- Response outputs stay stable while Rsp_Valid_o=1 and Rsp_Ready_i=0.
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored data. Only one request per cycle is possible (single port).
- Fault_Addr_o updates on the accepting edge of a faulted request and holds otherwise.
- Reset (rst_n=0 at an edge):
  - Rsp_Valid_o, Fault_o, Read_Data_o, Fault_Addr_o and all stage valids go to 0.
  - Req_Ready_o=0 throughout reset, so no write can occur.
  - In-flight responses are discarded.
  - Array contents are not reset.

Test Plan:
1. Store word 32'hDEADBEEF at 32'h1001_0000, then load word -> one store response with Fault_o=0 and Read_Data_o=0; load response READ_LATENCY cycles after accept with data 32'hDEADBEEF.
2. Store byte 8'h80 at 32'h1001_0002, then load byte signed and unsigned -> word becomes 32'hDE80BEEF; loads return 32'hFFFFFF80 and 32'h00000080.
3. Load half from 32'h1001_0001; store word to 32'h1001_0000+4*MEMORY_DEPTH; Size_i=11 -> each response has Fault_o=1 and data 0; Fault_Addr_o holds the latest bad address; the array is unchanged.
4. READ_LATENCY=3, loads issued back-to-back with Rsp_Ready_i=0 for 5 cycles -> Req_Ready_o drops once the first response is valid; responses stay stable during the stall and then drain in order; none are lost or duplicated.
5. Assert rst_n=0 with two loads in flight -> Rsp_Valid_o=0 the next cycle; no responses are emitted after release; earlier stored data is still readable.
